cp0_reg: RTL and testbench
==========================

CP0_REG -- requirements
Module: cp0_reg

Interface
- REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380: new PC for every exception.
- REQ-002 SHALL have parameter STATUS_RESET, default 32'h0040_0000: Status value at reset (BEV=1).
- REQ-003 SHALL use `clk` (input, 1): the single clock, rising edge.
- REQ-004 SHALL use `resetn` (input, 1): asynchronous, active-low reset.
- REQ-005 SHALL have `mem_valid` (input, 1): a valid instruction is in MEM.
- REQ-006 SHALL have `mem_excode` (input, 5) and `mem_exc_valid` (input, 1): synchronous exception code, and its flag.
- REQ-007 SHALL have `mem_pc` (input, 32), `mem_bad_vaddr` (input, 32) and `mem_in_ds` (input, 1): faulting PC, fault address, and branch-delay-slot flag.
- REQ-008 SHALL have `mem_eret` (input, 1): the MEM instruction is ERET.
- REQ-009 SHALL have `mem_we` (input, 1), `mem_waddr` (input, 5) and `mem_wdata` (input, 32): MTC0 write (sel fixed at 0).
- REQ-010 SHALL have `ex_raddr` (input, 5), `ex_re` (input, 1) and `rdata` (output, 32): MFC0 read port; `rdata` is combinational.
- REQ-011 SHALL have `stall_mem` (input, 1): MEM is held this cycle, so nothing commits.
- REQ-012 SHALL have `ext_int` (input, 6): hardware interrupt lines, level-sensitive.
- REQ-013 SHALL have `cp0_to_ctrl_bus` (output, 33): bit [32] is the redirect request; bits [31:0] are the new PC.
- REQ-014 SHALL have `stallreq_for_cp0` (output, 1): MFC0/MTC0 hazard stall request.

Function
- REQ-015 SHALL implement the registers BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14); any other address SHALL read 0 and ignore writes.
- REQ-016 Status SHALL have IM[15:8], EXL[1] and IE[0] writable; BEV[22] SHALL be read-only 1; all other bits SHALL read 0.
- REQ-017 Cause SHALL have IP[1:0] writable; IP[7:2] SHALL be loaded from ext_int every cycle, with IP[7] = ext_int[5] | TI.
- REQ-018 An interrupt SHALL be pending when IE=1, EXL=0 and (IP & IM) != 0.
- REQ-019 When mem_valid=1 and (interrupt pending or mem_exc_valid=1), bus[32] SHALL be 1 and bus[31:0] SHALL be EXC_VECTOR, combinationally in the same cycle; an interrupt SHALL take priority and use ExcCode 0.
- REQ-020 When mem_valid=1, mem_eret=1 and no exception applies, bus[32] SHALL be 1 and bus[31:0] SHALL be EPC.
- REQ-021 When neither REQ-019 nor REQ-020 applies, bus SHALL be 33'b0.
- REQ-022 Exception commit (on the edge, only when stall_mem=0) SHALL perform all of the following:
  - if EXL=0: set EPC = in_ds ? pc-4 : pc and Cause.BD = in_ds;
  - if EXL=1: leave EPC and BD unchanged;
  - write Cause.ExcCode;
  - set EXL=1;
  - set BadVAddr = mem_bad_vaddr only when ExcCode is 4 or 5.
- REQ-023 ERET commit SHALL clear EXL.
- REQ-024 When stall_mem=1, the bus SHALL still be driven, but no CP0 state SHALL change other than Count and Cause.IP[7:2].
- REQ-025 An MTC0 commits when mem_valid, mem_we and ~stall_mem are all 1, and SHALL be dropped when an exception commits in the same cycle.
- REQ-026 Count SHALL increment by 1 every second cycle, using an internal toggle flop, and SHALL wrap from 32'hFFFF_FFFF to 0.
- REQ-027 An MTC0 to Count SHALL override the same-cycle increment and clear the toggle flop.
- REQ-028 stallreq_for_cp0 SHALL be 1 when ex_re=1 and MEM holds a valid mtc0 with mem_waddr == ex_raddr; otherwise it SHALL be 0.
- REQ-029 rdata SHALL return the pre-write value; forwarding is not provided, because the stall in REQ-028 covers the hazard.

Reset
- REQ-030 On resetn=0, asynchronously:
  - Status SHALL be STATUS_RESET;
  - Cause, EPC, BadVAddr, Count, Compare and the toggle flop SHALL be 0;
  - the bus and stallreq SHALL be 0.
- REQ-031 A reset asserted mid-commit SHALL win; no partial update SHALL remain.

Configuration
- REQ-032 With macro CP0_TIMER_INT_EN defined:
  - when Count == Compare is reached through an increment, TI SHALL be set (sticky);
  - an MTC0 to Compare SHALL clear TI.
- REQ-033 With CP0_TIMER_INT_EN undefined:
  - TI SHALL be constant 0;
  - the Compare register SHALL be absent (reads 0, writes ignored);
  - Count SHALL still run.

Structure
- REQ-034 The shared package/defines SHALL hold:
  - CP0 register address constants;
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12);
  - CP0_TO_CTRL_WD=33.
- REQ-035 Exception/ERET priority selection SHALL be one sub-module, cp0_exc_arb, that outputs the request, new PC and commit type; register storage SHALL stay in cp0_reg.

Verification
- REQ-036 Scenario 1 (overflow exception): mem_pc=32'h8000_1000, excode=12, in_ds=0, EXL=0 -> same-cycle bus = {1, 32'hBFC0_0380}; after the edge, EPC=32'h8000_1000, ExcCode=12 and EXL=1.
- REQ-037 Scenario 2 (ERET): exception in a delay slot at pc 32'h8000_2004, then ERET -> EPC=32'h8000_2000 and BD=1; the ERET cycle drives bus = {1, 32'h8000_2000} and EXL returns to 0.
- REQ-038 Scenario 3 (interrupt vs. MTC0): Status=32'h0040_0401, ext_int[0]=1, with an mtc0 EPC=32'h1234 in the same cycle -> interrupt taken with ExcCode 0 and the EPC write dropped.
- REQ-039 Scenario 4 (timer): Compare=5 and Count written to 0 -> TI=1 after 10 cycles (with the macro defined); an MTC0 to Compare clears TI; with the macro undefined, TI stays 0.
- REQ-040 Scenario 5 (stall): stall_mem=1 with an AdEL at bad_vaddr 32'h0000_0003 -> bus asserted every stalled cycle, BadVAddr unchanged until the stall drops, then 32'h0000_0003.
- REQ-041 Scenario 6 (hazard): MEM holds mtc0 to reg 12 while EX holds mfc0 from reg 12 -> stallreq_for_cp0=1; for mfc0 from reg 13 -> 0.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg_pkg
// Description : Shared definitions for the CP0 register block. It holds the
//               CP0 register addresses, the exception codes, the width of the
//               redirect bus, the Status write mask and the commit type.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_reg_pkg;

  localparam int CP0_TO_CTRL_WD = 33;

  // CP0 register addresses (sel is always 0)
  localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ADDR_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status: IM[15:8], EXL[1], IE[0] are stored; BEV[22] always reads 1
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

  typedef enum logic [1:0] {
    COMMIT_NONE = 2'd0,
    COMMIT_EXC  = 2'd1,
    COMMIT_ERET = 2'd2
  } cp0_commit_e;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg_if
// Description : Pipeline <-> CP0 signal bundle.
//   master : pipeline side (drives MEM/EX stage info, receives results)
//   slave  : CP0 side
//   MEM  : mem_valid, mem_excode, mem_exc_valid, mem_pc, mem_bad_vaddr,
//          mem_in_ds, mem_eret, mem_we, mem_waddr, mem_wdata, stall_mem
//   EX   : ex_raddr, ex_re -> rdata (combinational)
//   misc : ext_int[5:0] -> cp0_to_ctrl_bus[32:0], stallreq_for_cp0
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_reg_if;
  import cp0_reg_pkg::*;

  logic                      mem_valid;
  logic [4:0]                mem_excode;
  logic                      mem_exc_valid;
  logic [31:0]               mem_pc;
  logic [31:0]               mem_bad_vaddr;
  logic                      mem_in_ds;
  logic                      mem_eret;
  logic                      mem_we;
  logic [4:0]                mem_waddr;
  logic [31:0]               mem_wdata;
  logic [4:0]                ex_raddr;
  logic                      ex_re;
  logic [31:0]               rdata;
  logic                      stall_mem;
  logic [5:0]                ext_int;
  logic [CP0_TO_CTRL_WD-1:0] cp0_to_ctrl_bus;
  logic                      stallreq_for_cp0;

  modport master (
    output mem_valid, mem_excode, mem_exc_valid, mem_pc, mem_bad_vaddr,
           mem_in_ds, mem_eret, mem_we, mem_waddr, mem_wdata,
           ex_raddr, ex_re, stall_mem, ext_int,
    input  rdata, cp0_to_ctrl_bus, stallreq_for_cp0
  );

  modport slave (
    input  mem_valid, mem_excode, mem_exc_valid, mem_pc, mem_bad_vaddr,
           mem_in_ds, mem_eret, mem_we, mem_waddr, mem_wdata,
           ex_raddr, ex_re, stall_mem, ext_int,
    output rdata, cp0_to_ctrl_bus, stallreq_for_cp0
  );

endinterface
`default_nettype wire

// File: rtl/cp0_exc_arb.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_arb
// Description : Exception / ERET priority selection for the MEM stage.
//               Interrupt > synchronous exception > ERET. Purely
//               combinational; stall gating of the commit is left to the
//               register block so the redirect still shows while stalled.
// Ports       : mem_valid_i, int_pending_i, exc_valid_i, excode_i, eret_i,
//               epc_i -> req_o, new_pc_o, commit_o, excode_o
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_arb
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        mem_valid_i,
  input  logic        int_pending_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  excode_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  output logic        req_o,
  output logic [31:0] new_pc_o,
  output cp0_commit_e commit_o,
  output logic [4:0]  excode_o
);

  always_comb begin
    req_o    = 1'b0;
    new_pc_o = 32'h0;
    commit_o = COMMIT_NONE;
    excode_o = excode_i;
    if (mem_valid_i) begin
      if (int_pending_i) begin
        req_o    = 1'b1;
        new_pc_o = EXC_VECTOR;
        commit_o = COMMIT_EXC;
        excode_o = EXC_INT;
      end else if (exc_valid_i) begin
        req_o    = 1'b1;
        new_pc_o = EXC_VECTOR;
        commit_o = COMMIT_EXC;
      end else if (eret_i) begin
        req_o    = 1'b1;
        new_pc_o = epc_i;
        commit_o = COMMIT_ERET;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg
// Description : MIPS CP0 register block: BadVAddr, Count, Compare, Status,
//               Cause, EPC. Takes exceptions/ERET from the MEM stage, drives
//               the redirect bus, and serves MFC0 reads from EX.
// Ports       : clk, resetn (async, active low), cp0_if (cp0_reg_if.slave)
// Config      : CP0_TIMER_INT_EN - when defined, Compare exists and a Count
//               increment that reaches Compare sets the sticky timer
//               interrupt TI (Cause[30], folded into IP[7]).
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic      clk,
  input  logic      resetn,
  cp0_reg_if.slave  cp0_if
);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic        tick_q,     tick_d;
  logic [31:0] status_q,   status_d;   // only STATUS_WMASK bits are held
  logic [31:0] epc_q,      epc_d;
  logic        bd_q,       bd_d;
  logic [5:0]  ip_hw_q,    ip_hw_d;    // Cause.IP[7:2]
  logic [1:0]  ip_sw_q,    ip_sw_d;    // Cause.IP[1:0]
  logic [4:0]  exccode_q,  exccode_d;
  logic        ti_w;

`ifdef CP0_TIMER_INT_EN
  logic [31:0] compare_q, compare_d;
  logic        ti_q,      ti_d;
  assign ti_w = ti_q;
`else
  assign ti_w = 1'b0;
`endif

  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [7:0]  ip_w;
  logic        int_pending;
  logic        arb_req;
  logic [31:0] arb_pc;
  cp0_commit_e arb_commit;
  logic [4:0]  arb_excode;
  logic        exc_commit;
  logic        eret_commit;
  logic        mtc0_commit;
  logic        wr_count;
  logic        wr_compare;

  assign status_rd = status_q | STATUS_BEV;
  assign cause_rd  = {bd_q, ti_w, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
  assign ip_w      = {ip_hw_q, ip_sw_q};

  assign int_pending = status_q[0] & ~status_q[1] & (|(ip_w & status_q[15:8]));

  cp0_exc_arb #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .mem_valid_i   (cp0_if.mem_valid),
    .int_pending_i (int_pending),
    .exc_valid_i   (cp0_if.mem_exc_valid),
    .excode_i      (cp0_if.mem_excode),
    .eret_i        (cp0_if.mem_eret),
    .epc_i         (epc_q),
    .req_o         (arb_req),
    .new_pc_o      (arb_pc),
    .commit_o      (arb_commit),
    .excode_o      (arb_excode)
  );

  assign exc_commit  = (arb_commit == COMMIT_EXC)  & ~cp0_if.stall_mem;
  assign eret_commit = (arb_commit == COMMIT_ERET) & ~cp0_if.stall_mem;
  // An exception in the same cycle squashes the MTC0
  assign mtc0_commit = cp0_if.mem_valid & cp0_if.mem_we & ~cp0_if.stall_mem & ~exc_commit;
  assign wr_count    = mtc0_commit & (cp0_if.mem_waddr == CP0_ADDR_COUNT);
  assign wr_compare  = mtc0_commit & (cp0_if.mem_waddr == CP0_ADDR_COMPARE);

  // Outputs are forced low while reset is asserted, whatever MEM presents
  assign cp0_if.cp0_to_ctrl_bus  = resetn ? {arb_req, arb_pc} : {CP0_TO_CTRL_WD{1'b0}};
  assign cp0_if.stallreq_for_cp0 = resetn & cp0_if.ex_re & cp0_if.mem_valid & cp0_if.mem_we &
                                   (cp0_if.mem_waddr == cp0_if.ex_raddr);

  // MFC0 sees the pre-write value; the hazard stall covers RAW
  always_comb begin
    cp0_if.rdata = 32'h0;
    case (cp0_if.ex_raddr)
      CP0_ADDR_BADVADDR: cp0_if.rdata = badvaddr_q;
      CP0_ADDR_COUNT:    cp0_if.rdata = count_q;
`ifdef CP0_TIMER_INT_EN
      CP0_ADDR_COMPARE:  cp0_if.rdata = compare_q;
`endif
      CP0_ADDR_STATUS:   cp0_if.rdata = status_rd;
      CP0_ADDR_CAUSE:    cp0_if.rdata = cause_rd;
      CP0_ADDR_EPC:      cp0_if.rdata = epc_q;
      default:           cp0_if.rdata = 32'h0;
    endcase
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    status_d   = status_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    // Hardware IP bits and Count keep running even while MEM is stalled
    ip_hw_d    = {cp0_if.ext_int[5] | ti_w, cp0_if.ext_int[4:0]};
    tick_d     = ~tick_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
`ifdef CP0_TIMER_INT_EN
    compare_d  = compare_q;
    ti_d       = ti_q;
    if (tick_q && !wr_count && !wr_compare && (count_q + 32'd1 == compare_q)) begin
      ti_d = 1'b1;
    end
`endif

    // BadVAddr is hardware-written only; MTC0 to it is ignored
    if (mtc0_commit) begin
      case (cp0_if.mem_waddr)
        CP0_ADDR_STATUS: status_d = cp0_if.mem_wdata & STATUS_WMASK;
        CP0_ADDR_CAUSE:  ip_sw_d  = cp0_if.mem_wdata[9:8];
        CP0_ADDR_EPC:    epc_d    = cp0_if.mem_wdata;
        CP0_ADDR_COUNT: begin
          count_d = cp0_if.mem_wdata;
          tick_d  = 1'b0;
        end
`ifdef CP0_TIMER_INT_EN
        CP0_ADDR_COMPARE: begin
          compare_d = cp0_if.mem_wdata;
          ti_d      = 1'b0;
        end
`endif
        default: ;
      endcase
    end

    if (exc_commit) begin
      // A nested exception keeps the original return point
      if (!status_q[1]) begin
        epc_d = cp0_if.mem_in_ds ? cp0_if.mem_pc - 32'd4 : cp0_if.mem_pc;
        bd_d  = cp0_if.mem_in_ds;
      end
      exccode_d   = arb_excode;
      status_d[1] = 1'b1;
      if (is_addr_exc(arb_excode)) begin
        badvaddr_d = cp0_if.mem_bad_vaddr;
      end
    end else if (eret_commit) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= 32'h0;
      count_q    <= 32'h0;
      tick_q     <= 1'b0;
      status_q   <= STATUS_RESET & STATUS_WMASK;
      epc_q      <= 32'h0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'h0;
      ip_sw_q    <= 2'h0;
      exccode_q  <= 5'h0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

`ifdef CP0_TIMER_INT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_q <= 32'h0;
      ti_q      <= 1'b0;
    end else begin
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_reg
// Description : Self-checking bench for cp0_reg. Stimulus tasks queue the
//               expected response; a negedge monitor pops and compares
//               whenever MEM or EX presents something to CP0.
// Config      : honours CP0_TIMER_INT_EN for timer expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_reg;
  import cp0_reg_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cp0_reg_if ifc();

  cp0_reg #(
    .EXC_VECTOR   (32'hBFC0_0380),
    .STATUS_RESET (32'h0040_0000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .cp0_if (ifc)
  );

  typedef struct {
    string       nm;
    logic [32:0] bus;
    logic        chk_rd;
    logic [31:0] rd;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [32:0] NOBUS = 33'd0;
  localparam logic [32:0] VEC   = {1'b1, 32'hBFC0_0380};

`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  // Monitor
  always @(negedge clk) begin
    if (ifc.mem_valid || ifc.ex_re) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_activity: nothing queued at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (ifc.cp0_to_ctrl_bus !== mon_e.bus) begin
          n_bad++;
          $display("FAIL %s.bus: got %h want %h", mon_e.nm, ifc.cp0_to_ctrl_bus, mon_e.bus);
        end
        n_cmp++;
        if (ifc.stallreq_for_cp0 !== mon_e.stall) begin
          n_bad++;
          $display("FAIL %s.stallreq: got %b want %b", mon_e.nm, ifc.stallreq_for_cp0, mon_e.stall);
        end
        if (mon_e.chk_rd) begin
          n_cmp++;
          if (ifc.rdata !== mon_e.rd) begin
            n_bad++;
            $display("FAIL %s.rdata: got %h want %h", mon_e.nm, ifc.rdata, mon_e.rd);
          end
        end
      end
    end
  end

  task automatic clr();
    ifc.mem_valid     = 1'b0;
    ifc.mem_excode    = 5'd0;
    ifc.mem_exc_valid = 1'b0;
    ifc.mem_pc        = 32'h0;
    ifc.mem_bad_vaddr = 32'h0;
    ifc.mem_in_ds     = 1'b0;
    ifc.mem_eret      = 1'b0;
    ifc.mem_we        = 1'b0;
    ifc.mem_waddr     = 5'd0;
    ifc.mem_wdata     = 32'h0;
    ifc.ex_raddr      = 5'd0;
    ifc.ex_re         = 1'b0;
    ifc.stall_mem     = 1'b0;
  endtask

  task automatic step(input string nm, input logic [32:0] eb, input logic cr,
                      input logic [31:0] er, input logic es);
    exp_t e;
    e.nm = nm; e.bus = eb; e.chk_rd = cr; e.rd = er; e.stall = es;
    exp_q.push_back(e);
    @(posedge clk); #1;
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input string nm);
    ifc.mem_valid = 1'b1; ifc.mem_we = 1'b1; ifc.mem_waddr = a; ifc.mem_wdata = d;
    step(nm, NOBUS, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic mfc0(input logic [4:0] a, input logic [31:0] x, input string nm);
    ifc.ex_re = 1'b1; ifc.ex_raddr = a;
    step(nm, NOBUS, 1'b1, x, 1'b0);
  endtask

  task automatic set_exc(input logic [4:0] code, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bva);
    ifc.mem_valid = 1'b1; ifc.mem_exc_valid = 1'b1; ifc.mem_excode = code;
    ifc.mem_pc = pc; ifc.mem_in_ds = ds; ifc.mem_bad_vaddr = bva;
  endtask

  task automatic eret(input logic [31:0] pc, input string nm);
    ifc.mem_valid = 1'b1; ifc.mem_eret = 1'b1;
    step(nm, {1'b1, pc}, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    ifc.ext_int = 6'd0;
    resetn = 1'b0;
    @(posedge clk); #1;

    // Outputs held low during reset even with a conflicting MEM/EX pattern
    set_exc(EXC_OV, 32'h8000_0000, 1'b0, 32'h0);
    ifc.mem_we = 1'b1; ifc.mem_waddr = CP0_ADDR_STATUS;
    ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_STATUS;
    step("reset_out", NOBUS, 1'b1, 32'h0040_0000, 1'b0);
    idle(1);
    resetn = 1'b1;

    mfc0(CP0_ADDR_COUNT,    32'h0,         "rst_count");
    mfc0(CP0_ADDR_STATUS,   32'h0040_0000, "rst_status");
    mfc0(CP0_ADDR_CAUSE,    32'h0,         "rst_cause");
    mfc0(CP0_ADDR_EPC,      32'h0,         "rst_epc");
    mfc0(CP0_ADDR_BADVADDR, 32'h0,         "rst_badvaddr");

    // Write masks and unimplemented addresses
    mtc0(CP0_ADDR_STATUS, 32'hFFFF_FFFF, "wr_status_ones");
    mfc0(CP0_ADDR_STATUS, 32'h0040_FF03, "status_mask");
    mtc0(CP0_ADDR_STATUS, 32'h0, "wr_status_zero");
    mtc0(CP0_ADDR_CAUSE, 32'hFFFF_FFFF, "wr_cause_ones");
    mfc0(CP0_ADDR_CAUSE, 32'h0000_0300, "cause_mask");
    mtc0(CP0_ADDR_CAUSE, 32'h0, "wr_cause_zero");
    mtc0(5'd0, 32'hDEAD_BEEF, "wr_unimpl");
    mfc0(5'd0, 32'h0, "rd_unimpl");
    mtc0(CP0_ADDR_COMPARE, 32'hFFFF_0000, "wr_compare");
    mfc0(CP0_ADDR_COMPARE, TIMER ? 32'hFFFF_0000 : 32'h0, "rd_compare");

    // Scenario 1: overflow exception
    set_exc(EXC_OV, 32'h8000_1000, 1'b0, 32'h0);
    step("s1_bus", VEC, 1'b0, 32'h0, 1'b0);
    mfc0(CP0_ADDR_EPC,    32'h8000_1000, "s1_epc");
    mfc0(CP0_ADDR_CAUSE,  32'h0000_0030, "s1_cause");
    mfc0(CP0_ADDR_STATUS, 32'h0040_0002, "s1_exl");
    eret(32'h8000_1000, "s1_eret_bus");
    mfc0(CP0_ADDR_STATUS, 32'h0040_0000, "s1_exl_clr");

    // Scenario 2: delay-slot exception, nested exception, ERET
    set_exc(EXC_RI, 32'h8000_2004, 1'b1, 32'hDEAD_0000);
    step("s2_bus", VEC, 1'b0, 32'h0, 1'b0);
    mfc0(CP0_ADDR_EPC,      32'h8000_2000, "s2_epc");
    mfc0(CP0_ADDR_CAUSE,    32'h8000_0028, "s2_cause_bd");
    mfc0(CP0_ADDR_BADVADDR, 32'h0,         "s2_badvaddr_keep");
    set_exc(EXC_SYS, 32'h8000_3000, 1'b0, 32'h0);
    step("s2_nested_bus", VEC, 1'b0, 32'h0, 1'b0);
    mfc0(CP0_ADDR_EPC,   32'h8000_2000, "s2_nested_epc");
    mfc0(CP0_ADDR_CAUSE, 32'h8000_0020, "s2_nested_cause");
    eret(32'h8000_2000, "s2_eret_bus");
    mfc0(CP0_ADDR_STATUS, 32'h0040_0000, "s2_exl_clr");

    // Scenario 3: interrupt beats a same-cycle MTC0 to EPC
    ifc.ext_int = 6'b000001;
    idle(2);
    mtc0(CP0_ADDR_STATUS, 32'h0040_0401, "s3_wr_status");
    ifc.mem_valid = 1'b1; ifc.mem_we = 1'b1; ifc.mem_waddr = CP0_ADDR_EPC;
    ifc.mem_wdata = 32'h0000_1234; ifc.mem_pc = 32'h8000_4000;
    step("s3_int_bus", VEC, 1'b0, 32'h0, 1'b0);
    ifc.ext_int = 6'b000000;
    mfc0(CP0_ADDR_CAUSE,  32'h0000_0400, "s3_cause");
    mfc0(CP0_ADDR_EPC,    32'h8000_4000, "s3_epc_no_mtc0");
    mfc0(CP0_ADDR_STATUS, 32'h0040_0403, "s3_status");
    mtc0(CP0_ADDR_STATUS, 32'h0, "s3_status_clr");

    // Scenario 5: AdEL held by stall_mem
    set_exc(EXC_ADEL, 32'h8000_5000, 1'b0, 32'h0000_0003);
    ifc.stall_mem = 1'b1; ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_BADVADDR;
    step("s5_stall0", VEC, 1'b1, 32'h0, 1'b0);
    set_exc(EXC_ADEL, 32'h8000_5000, 1'b0, 32'h0000_0003);
    ifc.stall_mem = 1'b1; ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_EPC;
    step("s5_stall1", VEC, 1'b1, 32'h8000_4000, 1'b0);
    set_exc(EXC_ADEL, 32'h8000_5000, 1'b0, 32'h0000_0003);
    ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_BADVADDR;
    step("s5_release", VEC, 1'b1, 32'h0, 1'b0);
    mfc0(CP0_ADDR_BADVADDR, 32'h0000_0003, "s5_badvaddr");
    mfc0(CP0_ADDR_EPC,      32'h8000_5000, "s5_epc");
    mfc0(CP0_ADDR_CAUSE,    32'h0000_0010, "s5_cause");
    mfc0(CP0_ADDR_STATUS,   32'h0040_0002, "s5_status");
    mtc0(CP0_ADDR_STATUS, 32'h0, "s5_status_clr");

    // Scenario 4: timer
    mtc0(CP0_ADDR_COMPARE, 32'd5, "s4_wr_compare");
    mtc0(CP0_ADDR_COUNT,   32'd0, "s4_wr_count");
    idle(10);
    mfc0(CP0_ADDR_CAUSE, TIMER ? 32'h4000_0010 : 32'h0000_0010, "s4_ti_set");
    mtc0(CP0_ADDR_COMPARE, 32'd5, "s4_clr_ti");
    mfc0(CP0_ADDR_CAUSE, TIMER ? 32'h0000_8010 : 32'h0000_0010, "s4_ti_clr");
    mfc0(CP0_ADDR_CAUSE, 32'h0000_0010, "s4_ip7_clr");

    // Scenario 6: MTC0/MFC0 hazard, with pre-write read data
    ifc.mem_valid = 1'b1; ifc.mem_we = 1'b1; ifc.mem_waddr = CP0_ADDR_EPC;
    ifc.mem_wdata = 32'hABCD_0000; ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_EPC;
    step("s6_hazard", NOBUS, 1'b1, 32'h8000_5000, 1'b1);
    mfc0(CP0_ADDR_EPC, 32'hABCD_0000, "s6_epc_written");
    ifc.mem_valid = 1'b1; ifc.mem_we = 1'b1; ifc.mem_waddr = CP0_ADDR_STATUS;
    ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_CAUSE;
    step("s6_no_match", NOBUS, 1'b1, 32'h0000_0010, 1'b0);
    ifc.mem_valid = 1'b0; ifc.mem_we = 1'b1; ifc.mem_waddr = CP0_ADDR_STATUS;
    ifc.ex_re = 1'b1; ifc.ex_raddr = CP0_ADDR_STATUS;
    step("s6_mem_invalid", NOBUS, 1'b1, 32'h0040_0000, 1'b0);
    ifc.mem_valid = 1'b1; ifc.mem_we = 1'b1; ifc.mem_waddr = CP0_ADDR_STATUS;
    ifc.ex_re = 1'b0; ifc.ex_raddr = CP0_ADDR_STATUS;
    step("s6_no_re", NOBUS, 1'b0, 32'h0, 1'b0);

    // Count: half-rate increment and wrap
    mtc0(CP0_ADDR_COUNT, 32'hFFFF_FFFF, "wr_count_max");
    mfc0(CP0_ADDR_COUNT, 32'hFFFF_FFFF, "count_hold0");
    mfc0(CP0_ADDR_COUNT, 32'hFFFF_FFFF, "count_hold1");
    mfc0(CP0_ADDR_COUNT, 32'h0,         "count_wrap");

    // Reset asserted while an exception would commit
    set_exc(EXC_ADEL, 32'h8000_6000, 1'b0, 32'h0000_0055);
    #1;
    resetn = 1'b0;
    step("rst_mid_bus", NOBUS, 1'b0, 32'h0, 1'b0);
    idle(1);
    resetn = 1'b1;
    mfc0(CP0_ADDR_COUNT,    32'h0,         "rst2_count");
    mfc0(CP0_ADDR_EPC,      32'h0,         "rst2_epc");
    mfc0(CP0_ADDR_BADVADDR, 32'h0,         "rst2_badvaddr");
    mfc0(CP0_ADDR_STATUS,   32'h0040_0000, "rst2_status");
    mfc0(CP0_ADDR_CAUSE,    32'h0,         "rst2_cause");

    idle(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expectations: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
